// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer shared by icache refill (IF) and the MEM stage.
// Breaks 1/2/4-byte accesses into single-byte RAM cycles and packs read bytes little-endian.
module mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int PRIO_MEM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  output logic              icache_we_o,
  output logic [ADDR_W-1:0] icache_waddr_o,
  output logic [31:0]       icache_winst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [2:0]        cnt, nbytes, idx;
  logic [31:0]       wdata, rbuf, rnext;
  logic [1:0]        bsel;
  logic              own_if, frz, busy, take_mem, take_if;

  assign take_mem = mem_req_i && (PRIO_MEM != 0 || !(if_req_i && !if_flush_i));
  assign take_if  = if_req_i && !if_flush_i && !take_mem;

  // Reads run one edge past the last issued byte; hold the address on the last byte.
  assign idx  = (cnt < nbytes) ? cnt : 3'(nbytes - 3'd1);
  assign busy = (state == IF_RD) || (state == MEM_RD) || (state == MEM_WR);
  assign bsel = cnt[1:0] - 2'd1;

  assign ram_a_o    = busy ? base + ADDR_W'(idx) : '0;
  assign ram_wr_o   = (state == MEM_WR) && rdy;
  assign ram_dout_o = (state == MEM_WR) ? wdata[{idx[1:0], 3'b000} +: 8] : 8'h00;

  always_comb begin
    rnext = rbuf;
    if (cnt != 3'd0) rnext[{bsel, 3'b000} +: 8] = ram_din_i;
  end

  function automatic logic [2:0] len2n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base           <= '0;
      cnt            <= '0;
      nbytes         <= '0;
      wdata          <= '0;
      rbuf           <= '0;
      own_if         <= 1'b0;
      frz            <= 1'b0;
      if_done_o      <= 1'b0;
      if_inst_o      <= '0;
      icache_we_o    <= 1'b0;
      icache_waddr_o <= '0;
      icache_winst_o <= '0;
      mem_done_o     <= 1'b0;
      mem_rdata_o    <= '0;
    end else begin
      frz <= !rdy;
      if (rdy) begin
        if_done_o   <= 1'b0;
        mem_done_o  <= 1'b0;
        icache_we_o <= 1'b0;
        case (state)
          IDLE: begin
            cnt  <= '0;
            rbuf <= '0;
            if (take_mem) begin
              state  <= mem_we_i ? MEM_WR : MEM_RD;
              base   <= mem_addr_i;
              nbytes <= len2n(mem_len_i);
              wdata  <= mem_wdata_i;
              own_if <= 1'b0;
            end else if (take_if) begin
              state  <= IF_RD;
              base   <= if_addr_i;
              nbytes <= 3'd4;
              own_if <= 1'b1;
            end
          end
          IF_RD, MEM_RD: begin
            if (state == IF_RD && if_flush_i) begin
              state <= IDLE;
            end else if (frz) begin
              // RAM data in flight across a freeze is stale: reissue from byte 0.
              cnt <= '0;
            end else begin
              rbuf <= rnext;
              if (cnt == nbytes) begin
                state <= DONE;
                if (own_if) begin
                  if_done_o      <= 1'b1;
                  icache_we_o    <= 1'b1;
                  if_inst_o      <= rnext;
                  icache_winst_o <= rnext;
                  icache_waddr_o <= base;
                end else begin
                  mem_done_o  <= 1'b1;
                  mem_rdata_o <= rnext;
                end
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          MEM_WR: begin
            if (cnt == 3'(nbytes - 3'd1)) begin
              state      <= DONE;
              mem_done_o <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: two instances (PRIO_MEM=1 and 0) on a shared byte RAM model.
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  always #5 clk = ~clk;

  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, ic_we, mem_done, wr0;
  logic [31:0] if_inst, ic_waddr, ic_winst, mem_rdata, a0;
  logic [7:0]  din0, dout0;

  logic        if_req1, mem_req1, if_done1, ic_we1, mem_done1, wr1;
  logic [31:0] if_inst1, ic_waddr1, ic_winst1, mem_rdata1, a1;
  logic [7:0]  din1, dout1;

  logic [7:0]  ram [0:4095];
  logic [31:0] wa [8];
  logic [7:0]  wd [8];
  int n_err = 0, n_chk = 0;

  mem_ctrl #(.ADDR_W(32), .PRIO_MEM(1)) u0 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_done_o(if_done), .if_inst_o(if_inst),
    .icache_we_o(ic_we), .icache_waddr_o(ic_waddr), .icache_winst_o(ic_winst),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_len_i(mem_len),
    .mem_wdata_i(mem_wdata), .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
    .ram_din_i(din0), .ram_dout_o(dout0), .ram_a_o(a0), .ram_wr_o(wr0));

  mem_ctrl #(.ADDR_W(32), .PRIO_MEM(0)) u1 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req1), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_done_o(if_done1), .if_inst_o(if_inst1),
    .icache_we_o(ic_we1), .icache_waddr_o(ic_waddr1), .icache_winst_o(ic_winst1),
    .mem_req_i(mem_req1), .mem_we_i(1'b0), .mem_addr_i(mem_addr), .mem_len_i(mem_len),
    .mem_wdata_i(mem_wdata), .mem_done_o(mem_done1), .mem_rdata_o(mem_rdata1),
    .ram_din_i(din1), .ram_dout_o(dout1), .ram_a_o(a1), .ram_wr_o(wr1));

  // Synchronous-read byte RAM; only u0 ever writes.
  always @(posedge clk) begin
    din0 <= ram[a0[11:0]];
    din1 <= ram[a1[11:0]];
    if (wr0) ram[a0[11:0]] <= dout0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Run one u0 transaction whose request is already raised; edge 1 is the accept edge.
  task automatic run(input int frz_at, input int frz_len, output int edges, output int nw,
                     output bit saw_if);
    bit fin = 0;
    edges = 0; nw = 0; saw_if = 0;
    while (!fin && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (!rdy) chk("frz_wr", {31'b0, wr0}, 32'h0);
      if (wr0 && nw < 8) begin wa[nw] = a0; wd[nw] = dout0; nw++; end
      if (if_done || mem_done) begin
        fin = 1;
        if (if_done) begin saw_if = 1; chk("ic_we", {31'b0, ic_we}, 32'h1); end
        if_req = 0; mem_req = 0;
      end
      if (frz_len > 0 && edges == frz_at) rdy = 0;
      if (frz_len > 0 && edges == frz_at + frz_len) rdy = 1;
    end
    if (!fin) chk("timeout", 32'h1, 32'h0);
    @(posedge clk); #1;
    chk("pulse", {31'b0, if_done | mem_done}, 32'h0);
  endtask

  initial begin
    int e, nw, m0, i0, m1, i1;
    bit sif;
    logic [7:0] exp_b [4];
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    ram[12'h202] = 8'hFE; ram[12'h203] = 8'hFF;
    if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0;
    mem_len = 0; mem_wdata = 0; if_req1 = 0; mem_req1 = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a", a0, 32'h0);
    chk("rst_wr", {31'b0, wr0}, 32'h0);
    chk("rst_done", {30'b0, if_done, mem_done}, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    rst = 0;

    // Instruction fetch refill
    @(negedge clk); if_addr = 32'h100; if_req = 1;
    run(0, 0, e, nw, sif);
    chk("if_lat", e, 6);
    chk("if_inst", if_inst, 32'h0000_0513);
    chk("ic_waddr", ic_waddr, 32'h100);
    chk("ic_winst", ic_winst, 32'h0000_0513);

    // Half load, zero-extended
    @(negedge clk); mem_addr = 32'h202; mem_len = 2'b01; mem_we = 0; mem_req = 1;
    run(0, 0, e, nw, sif);
    chk("ldh_lat", e, 4);
    chk("ldh_data", mem_rdata, 32'h0000_FFFE);

    // Word store then load back
    @(negedge clk); mem_addr = 32'h300; mem_len = 2'b10; mem_we = 1;
    mem_wdata = 32'hDEAD_BEEF; mem_req = 1;
    run(0, 0, e, nw, sif);
    chk("st_lat", e, 5);
    chk("st_nwr", nw, 4);
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    for (int k = 0; k < 4; k++) begin
      chk("st_addr", wa[k], 32'h300 + 32'(k));
      chk("st_byte", {24'b0, wd[k]}, {24'b0, exp_b[k]});
    end
    @(negedge clk); mem_we = 0; mem_req = 1;
    run(0, 0, e, nw, sif);
    chk("ldw_lat", e, 6);
    chk("ldw_data", mem_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests on both instances
    @(negedge clk); if_addr = 32'h100; mem_addr = 32'h300; mem_len = 2'b10; mem_we = 0;
    if_req = 1; mem_req = 1; if_req1 = 1; mem_req1 = 1;
    m0 = 0; i0 = 0; m1 = 0; i1 = 0;
    for (int t = 1; t <= 30 && (m0 == 0 || i0 == 0 || m1 == 0 || i1 == 0); t++) begin
      @(posedge clk); #1;
      if (mem_done)  begin m0 = t; mem_req = 0; end
      if (if_done)   begin i0 = t; if_req = 0; end
      if (mem_done1) begin m1 = t; mem_req1 = 0; end
      if (if_done1)  begin i1 = t; if_req1 = 0; end
    end
    chk("prio1_mem", m0, 6);
    chk("prio1_if", i0, 13);
    chk("prio0_if", i1, 6);
    chk("prio0_mem", m1, 13);
    chk("prio0_inst", if_inst1, 32'h0000_0513);
    chk("prio0_data", mem_rdata1, 32'hDEAD_BEEF);
    if_req = 0; mem_req = 0; if_req1 = 0; mem_req1 = 0;
    repeat (2) @(posedge clk);

    // Flush two cycles into a fetch, MEM waiting behind it
    @(negedge clk); if_addr = 32'h100; if_req = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); if_flush = 1; mem_req = 1; mem_we = 0; mem_addr = 32'h202; mem_len = 2'b00;
    @(posedge clk); #1;
    chk("flush_idle", a0, 32'h0);
    chk("flush_done", {31'b0, if_done | ic_we}, 32'h0);
    @(negedge clk); if_req = 0; if_flush = 0;
    run(0, 0, e, nw, sif);
    chk("flush_mem_lat", e, 3);
    chk("flush_no_if", {31'b0, sif}, 32'h0);
    chk("ldb_data", mem_rdata, 32'h0000_00FE);

    // Freeze in the middle of a store and of a load
    @(negedge clk); mem_addr = 32'h310; mem_len = 2'b10; mem_we = 1;
    mem_wdata = 32'h1122_3344; mem_req = 1;
    run(2, 3, e, nw, sif);
    chk("frz_st_lat", e, 8);
    chk("frz_st_nwr", nw, 4);
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      chk("frz_st_addr", wa[k], 32'h310 + 32'(k));
      chk("frz_st_byte", {24'b0, wd[k]}, {24'b0, exp_b[k]});
    end
    @(negedge clk); mem_we = 0; mem_req = 1;
    run(2, 3, e, nw, sif);
    chk("frz_ld_lat", e, 11);
    chk("frz_ld_data", mem_rdata, 32'h1122_3344);

    // Reset in the middle of a store
    @(negedge clk); mem_addr = 32'h320; mem_wdata = 32'hAABB_CCDD; mem_we = 1; mem_req = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rstmid_wr", {31'b0, wr0}, 32'h0);
    chk("rstmid_a", a0, 32'h0);
    chk("rstmid_dout", {24'b0, dout0}, 32'h0);
    chk("rstmid_rdata", mem_rdata, 32'h0);
    chk("rstmid_inst", if_inst, 32'h0);
    @(negedge clk); rst = 0; mem_req = 0; mem_we = 0;
    chk("rstmid_partial", {24'b0, ram[12'h320]}, 32'h0000_00DD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
